sys_fsm: RTL and testbench
==========================

SYS_FSM -- requirements
Module: sys_fsm

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, SHALL set the clock cycles per one-second tick.
REQ-002 Parameter WAIT_SEC, default 5, range 1..15, SHALL set the error countdown length in seconds.
REQ-003 clk  in  1  SHALL be the single system clock; all logic is rising-edge.
REQ-004 rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-005 btn_confirm, btn_back  in  1 each  SHALL be debounced one-cycle pulses.
REQ-006 mode_sel  in  3  SHALL be the menu selection, sampled on btn_confirm.
REQ-007 input_done/input_err, gen_done, store_done/store_err, select_done/select_err, compute_done/compute_err  in  1 each  SHALL be one-cycle sub-unit completion/error pulses.
REQ-008 state  out  4  SHALL be the registered state code driven to the LED status display.
REQ-009 start_input, start_gen, start_store, start_select, start_compute  out  1 each  SHALL be one-cycle start pulses.
REQ-010 countdown  out  4  SHALL be the remaining seconds in WAIT, for 7-seg display.

Function
REQ-011 State codes SHALL be fixed: IDLE=0, MENU=1, INPUT=2, GEN=3, DISPLAY=4, COMPUTE=5, ERROR=6, STORE=7, SELECT=8, WAIT=9; codes 10-15 SHALL be unreachable and SHALL recover to IDLE next cycle.
REQ-012 IDLE: btn_confirm -> MENU.
REQ-013 MENU: btn_confirm with mode_sel 0 -> INPUT, 1 -> GEN, 2 -> DISPLAY, 3 -> SELECT, 4-7 -> ERROR; btn_back -> IDLE.
REQ-014 INPUT: input_err -> ERROR; input_done -> STORE; btn_back -> MENU.
REQ-015 GEN: gen_done -> STORE; btn_back SHALL be ignored.
REQ-016 STORE: store_err -> ERROR; store_done -> MENU.
REQ-017 SELECT: select_err -> ERROR; select_done -> COMPUTE; btn_back -> MENU.
REQ-018 COMPUTE: compute_err -> ERROR; compute_done -> DISPLAY.
REQ-019 DISPLAY: btn_confirm or btn_back -> MENU.
REQ-020 ERROR SHALL last exactly one cycle, then -> WAIT with countdown loaded to WAIT_SEC.
REQ-021 WAIT: countdown SHALL decrement on each one-second tick; the tick at countdown==1 SHALL go to MENU with countdown 0; buttons SHALL be ignored.
REQ-022 The tick prescaler SHALL clear on WAIT entry, so the first decrement occurs exactly CLK_FREQ cycles after entry.
REQ-023 Simultaneous events in one cycle SHALL take priority err > done > btn_confirm > btn_back.
REQ-024 A start_* pulse SHALL be high only in the first cycle of its state: INPUT, GEN, STORE, SELECT or COMPUTE respectively.
REQ-025 Pulses from sub-units not owning the current state SHALL be ignored.
REQ-026 countdown SHALL be 0 outside WAIT; state and all outputs SHALL be registered, with a one-cycle transition latency.

Reset
REQ-027 When rst_n=0 at a clock edge, the next-cycle values SHALL be state=IDLE, countdown=0, all start_* 0 and the prescaler 0, regardless of the current state, including mid-WAIT.

Structure
REQ-028 The state code localparams and the 4-bit state width SHALL live in shared package sys_pkg, also used by the LED status display.
REQ-029 The one-second prescaler SHALL be sub-module sec_tick, with inputs clr and en and output tick.

Verification (CLK_FREQ=10, WAIT_SEC=3)
REQ-030 Reset, then btn_confirm, then btn_confirm with mode_sel=0 -> state 0 -> 1 -> 2; start_input high for exactly one cycle.
REQ-031 In INPUT, pulse input_done -> STORE with start_store; then store_done -> MENU.
REQ-032 mode_sel=3, then select_done, then compute_err pulsed together with compute_done -> 8 -> 5 -> 6 -> 9; countdown 3, 2, 1 at 10-cycle intervals; MENU after cycle 30 of WAIT.
REQ-033 mode_sel=6 on btn_confirm -> ERROR for one cycle, then WAIT; btn_confirm during WAIT has no effect.
REQ-034 rst_n low mid-WAIT with countdown=2 -> next cycle state=0 and countdown=0.
REQ-035 Force the state register to 12 -> IDLE next cycle; gen_done pulsed while in MENU -> no state change.

Source files
------------

// File: rtl/sys_pkg.sv
// sys_pkg: shared definitions for the system controller FSM and the LED
// status display that decodes its state code.
//   STATE_W  - width of the state code bus
//   state_t  - fixed state encodings (codes 10-15 unused)
//   CD_W     - width of the WAIT countdown (7-seg digit)
package sys_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CD_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_MENU    = 4'd1,
        ST_INPUT   = 4'd2,
        ST_GEN     = 4'd3,
        ST_DISPLAY = 4'd4,
        ST_COMPUTE = 4'd5,
        ST_ERROR   = 4'd6,
        ST_STORE   = 4'd7,
        ST_SELECT  = 4'd8,
        ST_WAIT    = 4'd9
    } state_t;

endpackage

// File: rtl/sec_tick.sv
// sec_tick: one-second prescaler.
//   clk, rst_n - system clock, synchronous active-low reset
//   clr        - restart the count from zero (takes priority over en)
//   en         - count enable
//   tick       - high for the last cycle of each CLK_FREQ-cycle period while en
module sec_tick #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sys_fsm.sv
// sys_fsm: top-level system controller.
//   clk, rst_n        - system clock, synchronous active-low reset
//   btn_confirm/back  - debounced one-cycle button pulses
//   mode_sel          - menu selection, sampled with btn_confirm in MENU
//   *_done / *_err    - one-cycle completion/error pulses from sub-units
//   state             - registered state code for the LED status display
//   start_*           - one-cycle start pulses, high in the first cycle of
//                       INPUT, GEN, STORE, SELECT, COMPUTE
//   countdown         - seconds remaining in WAIT, 0 elsewhere
module sys_fsm
    import sys_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned WAIT_SEC = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_confirm,
    input  logic               btn_back,
    input  logic [2:0]         mode_sel,
    input  logic               input_done,
    input  logic               input_err,
    input  logic               gen_done,
    input  logic               store_done,
    input  logic               store_err,
    input  logic               select_done,
    input  logic               select_err,
    input  logic               compute_done,
    input  logic               compute_err,
    output logic [STATE_W-1:0] state,
    output logic               start_input,
    output logic               start_gen,
    output logic               start_store,
    output logic               start_select,
    output logic               start_compute,
    output logic [CD_W-1:0]    countdown
);

    state_t state_r;
    state_t nxt;
    logic   tick;
    logic   wait_entry;

    assign state      = state_r;
    // Clearing on entry makes the first decrement land CLK_FREQ cycles later.
    assign wait_entry = (nxt == ST_WAIT) && (state_r != ST_WAIT);

    sec_tick #(
        .CLK_FREQ(CLK_FREQ)
    ) u_sec_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (wait_entry),
        .en   (state_r == ST_WAIT),
        .tick (tick)
    );

    // Within each state the if-chain order gives err > done > confirm > back;
    // pulses from units not owning the state are simply not looked at.
    always_comb begin
        nxt = state_r;
        case (state_r)
            ST_IDLE:    if (btn_confirm) nxt = ST_MENU;
            ST_MENU: begin
                if (btn_confirm) begin
                    case (mode_sel)
                        3'd0:    nxt = ST_INPUT;
                        3'd1:    nxt = ST_GEN;
                        3'd2:    nxt = ST_DISPLAY;
                        3'd3:    nxt = ST_SELECT;
                        default: nxt = ST_ERROR;
                    endcase
                end else if (btn_back) begin
                    nxt = ST_IDLE;
                end
            end
            ST_INPUT: begin
                if (input_err)       nxt = ST_ERROR;
                else if (input_done) nxt = ST_STORE;
                else if (btn_back)   nxt = ST_MENU;
            end
            ST_GEN:     if (gen_done) nxt = ST_STORE;
            ST_STORE: begin
                if (store_err)       nxt = ST_ERROR;
                else if (store_done) nxt = ST_MENU;
            end
            ST_SELECT: begin
                if (select_err)       nxt = ST_ERROR;
                else if (select_done) nxt = ST_COMPUTE;
                else if (btn_back)    nxt = ST_MENU;
            end
            ST_COMPUTE: begin
                if (compute_err)       nxt = ST_ERROR;
                else if (compute_done) nxt = ST_DISPLAY;
            end
            ST_DISPLAY: if (btn_confirm || btn_back) nxt = ST_MENU;
            ST_ERROR:   nxt = ST_WAIT;
            ST_WAIT:    if (tick && (countdown <= CD_W'(1))) nxt = ST_MENU;
            default:    nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            countdown     <= '0;
            start_input   <= 1'b0;
            start_gen     <= 1'b0;
            start_store   <= 1'b0;
            start_select  <= 1'b0;
            start_compute <= 1'b0;
        end else begin
            state_r       <= nxt;
            start_input   <= (nxt == ST_INPUT)   && (state_r != ST_INPUT);
            start_gen     <= (nxt == ST_GEN)     && (state_r != ST_GEN);
            start_store   <= (nxt == ST_STORE)   && (state_r != ST_STORE);
            start_select  <= (nxt == ST_SELECT)  && (state_r != ST_SELECT);
            start_compute <= (nxt == ST_COMPUTE) && (state_r != ST_COMPUTE);
            if (nxt != ST_WAIT) begin
                countdown <= '0;
            end else if (wait_entry) begin
                countdown <= CD_W'(WAIT_SEC);
            end else if (tick) begin
                countdown <= countdown - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sys_fsm.sv
// tb_sys_fsm: scoreboard bench for sys_fsm (CLK_FREQ=10, WAIT_SEC=3).
// Stimulus pushes expected {state, start pulses, countdown} tagged with the
// cycle they must appear in; a monitor pops and compares mid-cycle.
module tb_sys_fsm;
    import sys_pkg::*;

    localparam int unsigned CF = 10;
    localparam int unsigned WS = 3;

    localparam logic [4:0] SI = 5'b10000;
    localparam logic [4:0] SG = 5'b01000;
    localparam logic [4:0] SS = 5'b00100;
    localparam logic [4:0] SL = 5'b00010;
    localparam logic [4:0] SC = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_confirm, btn_back;
    logic [2:0] mode_sel;
    logic       input_done, input_err, gen_done, store_done, store_err;
    logic       select_done, select_err, compute_done, compute_err;
    logic [3:0] state;
    logic       start_input, start_gen, start_store, start_select, start_compute;
    logic [3:0] countdown;

    sys_fsm #(
        .CLK_FREQ(CF),
        .WAIT_SEC(WS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_confirm  (btn_confirm),
        .btn_back     (btn_back),
        .mode_sel     (mode_sel),
        .input_done   (input_done),
        .input_err    (input_err),
        .gen_done     (gen_done),
        .store_done   (store_done),
        .store_err    (store_err),
        .select_done  (select_done),
        .select_err   (select_err),
        .compute_done (compute_done),
        .compute_err  (compute_err),
        .state        (state),
        .start_input  (start_input),
        .start_gen    (start_gen),
        .start_store  (start_store),
        .start_select (start_select),
        .start_compute(start_compute),
        .countdown    (countdown)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [3:0]  st;
        logic [4:0]  sp;
        logic [3:0]  cd;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [4:0] starts;
    assign starts = {start_input, start_gen, start_store, start_select, start_compute};

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: expectation for cycle %0d still pending at cycle %0d",
                         e.name, e.cyc, cyc);
            end else if (state !== e.st || starts !== e.sp || countdown !== e.cd) begin
                fails++;
                $display("FAIL %s: got state=%0d starts=%b countdown=%0d, expected state=%0d starts=%b countdown=%0d",
                         e.name, state, starts, countdown, e.st, e.sp, e.cd);
            end
        end
    end

    task automatic clear_pulses();
        btn_confirm  = 1'b0;
        btn_back     = 1'b0;
        input_done   = 1'b0;
        input_err    = 1'b0;
        gen_done     = 1'b0;
        store_done   = 1'b0;
        store_err    = 1'b0;
        select_done  = 1'b0;
        select_err   = 1'b0;
        compute_done = 1'b0;
        compute_err  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply currently driven inputs for one edge, then expect the result.
    task automatic go(input string nm, input logic [3:0] st,
                      input logic [4:0] sp, input logic [3:0] cd);
        exp_t e;
        step();
        clear_pulses();
        e.cyc  = cyc;
        e.name = nm;
        e.st   = st;
        e.sp   = sp;
        e.cd   = cd;
        q.push_back(e);
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_sel = 3'd0;
        clear_pulses();
        step();
        go("reset", 4'd0, 5'b0, 4'd0);
        rst_n = 1'b1;
        go("idle_hold", 4'd0, 5'b0, 4'd0);

        btn_confirm = 1'b1;
        go("idle_to_menu", 4'd1, 5'b0, 4'd0);
        mode_sel = 3'd0; btn_confirm = 1'b1;
        go("menu_to_input", 4'd2, SI, 4'd0);
        go("input_start_once", 4'd2, 5'b0, 4'd0);
        input_done = 1'b1;
        go("input_done", 4'd7, SS, 4'd0);
        go("store_start_once", 4'd7, 5'b0, 4'd0);
        store_done = 1'b1;
        go("store_done", 4'd1, 5'b0, 4'd0);

        gen_done = 1'b1;
        go("menu_ignores_gen_done", 4'd1, 5'b0, 4'd0);

        mode_sel = 3'd1; btn_confirm = 1'b1;
        go("menu_to_gen", 4'd3, SG, 4'd0);
        btn_back = 1'b1;
        go("gen_ignores_back", 4'd3, 5'b0, 4'd0);
        gen_done = 1'b1;
        go("gen_done", 4'd7, SS, 4'd0);
        store_done = 1'b1;
        go("gen_store_done", 4'd1, 5'b0, 4'd0);

        mode_sel = 3'd0; btn_confirm = 1'b1;
        go("menu_to_input_2", 4'd2, SI, 4'd0);
        input_done = 1'b1; btn_back = 1'b1;
        go("input_done_beats_back", 4'd7, SS, 4'd0);
        store_done = 1'b1;
        go("store_done_2", 4'd1, 5'b0, 4'd0);

        mode_sel = 3'd2; btn_confirm = 1'b1; btn_back = 1'b1;
        go("menu_confirm_beats_back", 4'd4, 5'b0, 4'd0);
        btn_confirm = 1'b1;
        go("display_to_menu", 4'd1, 5'b0, 4'd0);

        mode_sel = 3'd3; btn_confirm = 1'b1;
        go("menu_to_select", 4'd8, SL, 4'd0);
        select_done = 1'b1;
        go("select_done", 4'd5, SC, 4'd0);
        compute_err = 1'b1; compute_done = 1'b1;
        go("compute_err_beats_done", 4'd6, 5'b0, 4'd0);
        go("error_one_cycle", 4'd9, 5'b0, 4'd3);
        for (int i = 1; i <= 30; i++) begin
            btn_confirm = (i == 5);
            btn_back    = (i == 15);
            if (i == 30)
                go($sformatf("wait1_c%0d", i), 4'd1, 5'b0, 4'd0);
            else
                go($sformatf("wait1_c%0d", i), 4'd9, 5'b0,
                   (i < 10) ? 4'd3 : ((i < 20) ? 4'd2 : 4'd1));
        end

        mode_sel = 3'd6; btn_confirm = 1'b1;
        go("menu_bad_mode", 4'd6, 5'b0, 4'd0);
        btn_confirm = 1'b1;
        go("error_to_wait", 4'd9, 5'b0, 4'd3);
        for (int i = 1; i <= 12; i++) begin
            btn_confirm = (i == 1);
            go($sformatf("wait2_c%0d", i), 4'd9, 5'b0, (i < 10) ? 4'd3 : 4'd2);
        end
        rst_n = 1'b0;
        go("reset_mid_wait", 4'd0, 5'b0, 4'd0);
        rst_n = 1'b1;
        go("post_reset_idle", 4'd0, 5'b0, 4'd0);

        // Plant an unused code between checks and expect recovery.
        @(negedge clk);
        #1;
        force dut.state_r = state_t'(4'd12);
        #1;
        release dut.state_r;
        go("illegal_recover", 4'd0, 5'b0, 4'd0);
        btn_confirm = 1'b1;
        go("recovered_to_menu", 4'd1, 5'b0, 4'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
